// File: rtl/tsqr_pkg.sv
// rtl/tsqr_pkg.sv - shared parameters, types and helpers for the TSQR sequencer
package tsqr_pkg;

    localparam int BW         = 64;
    localparam int TILE_ROWS  = 4;
    localparam int TILE_COLS  = 2;
    localparam int MAX_TILES  = 16;
    localparam int R_WORDS    = TILE_COLS * (TILE_COLS + 1) / 2;

    localparam int TILE_WORDS = TILE_ROWS * TILE_COLS;
    localparam int DM0_DEPTH  = MAX_TILES * TILE_WORDS;
    localparam int DM0_AW     = $clog2(DM0_DEPTH);
    localparam int TRI_AW     = $clog2(R_WORDS);
    // Address counter must also hold the one-past-last value used to detect the end of a stream
    localparam int CNT_W      = $clog2(DM0_DEPTH + 1);
    localparam int N_W        = $clog2(MAX_TILES + 1);

    typedef logic [BW-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM0,
        ST_MEM1,
        ST_DONE
    } tsqr_state_e;

    // Requested tile count saturated to what dm0 can hold
    function automatic logic [N_W-1:0] clamp_tiles(input logic [31:0] mx_no);
        if (mx_no > 32'(MAX_TILES)) begin
            return N_W'(MAX_TILES);
        end
        return mx_no[N_W-1:0];
    endfunction

endpackage

// File: rtl/tsqr_sp_ram.sv
// rtl/tsqr_sp_ram.sv - single-port RAM wrapper exposing the array as mem_0_ext.Memory
module tsqr_sp_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    tsqr_sp_ram_ext #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) mem_0_ext (
        .clk_i   (clk_i),
        .en_i    (en_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );

endmodule

// File: rtl/tsqr_sp_ram_ext.sv
// rtl/tsqr_sp_ram_ext.sv - single-port storage array with 1-cycle synchronous read
module tsqr_sp_ram_ext #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] Memory [0:DEPTH-1];

    // Write on we, otherwise register the addressed word; contents survive reset
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                Memory[addr_i] <= wdata_i;
            end else begin
                rdata_o <= Memory[addr_i];
            end
        end
    end

endmodule

// File: rtl/tsqr_top.sv
// rtl/tsqr_top.sv - TSQR sequencer: streams dm0 tiles, then the R factor from tri_0
module tsqr_top
    import tsqr_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_tsqr_en,
    input  logic [31:0] io_mx_no,
    output logic        io_mem0_fi,
    output logic        io_mem1_fi,
    output logic        io_r_vld,
    output word_t       io_r_0,
    output logic        io_tsqr_fi
);

    tsqr_state_e       state_q, state_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  total_words;
    word_t             r_hold_q, r_hold_d;
    logic              tile_vld_q;

    logic              dm0_en;
    logic [DM0_AW-1:0] dm0_addr;
    word_t             dm0_rdata;
    logic              tri_en;
    logic [TRI_AW-1:0] tri_addr;
    word_t             tri_rdata;

    logic              mem0_fi, mem1_fi, r_vld, tsqr_fi, abort;

    word_t             tile_data;
    logic              tile_vld;
    logic [BW:0]       qr_core_unused;

    assign total_words = CNT_W'(n_q) * CNT_W'(TILE_WORDS);

    tsqr_sp_ram #(
        .DEPTH (DM0_DEPTH),
        .WIDTH (BW),
        .AW    (DM0_AW)
    ) dm0 (
        .clk_i   (clock),
        .en_i    (dm0_en),
        .we_i    (1'b0),
        .addr_i  (dm0_addr),
        .wdata_i ('0),
        .rdata_o (dm0_rdata)
    );

    tsqr_sp_ram #(
        .DEPTH (R_WORDS),
        .WIDTH (BW),
        .AW    (TRI_AW)
    ) tri_0 (
        .clk_i   (clock),
        .en_i    (tri_en),
        .we_i    (1'b0),
        .addr_i  (tri_addr),
        .wdata_i ('0),
        .rdata_o (tri_rdata)
    );

    // Next-state, address generation and phase pulses; enable low mid-run aborts with quiet outputs
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        r_hold_d = r_hold_q;
        dm0_en   = 1'b0;
        dm0_addr = '0;
        tri_en   = 1'b0;
        tri_addr = '0;
        mem0_fi  = 1'b0;
        mem1_fi  = 1'b0;
        r_vld    = 1'b0;
        tsqr_fi  = 1'b0;
        abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (io_tsqr_en) begin
                    n_d     = clamp_tiles(io_mx_no);
                    state_d = ST_MEM0;
                end
            end
            ST_MEM0: begin
                if (!io_tsqr_en) begin
                    abort   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q < total_words) begin
                    dm0_en   = 1'b1;
                    dm0_addr = cnt_q[DM0_AW-1:0];
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    mem0_fi = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_MEM1;
                end
            end
            ST_MEM1: begin
                if (!io_tsqr_en) begin
                    abort   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    // cnt_q is the address being issued; the word for cnt_q-1 is on the RAM output
                    if (cnt_q < CNT_W'(R_WORDS)) begin
                        tri_en   = 1'b1;
                        tri_addr = cnt_q[TRI_AW-1:0];
                    end
                    if (cnt_q != '0) begin
                        r_vld = 1'b1;
                    end
                    if (cnt_q == CNT_W'(R_WORDS)) begin
                        mem1_fi = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                tsqr_fi = 1'b1;
                if (!io_tsqr_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            r_hold_d = '0;
        end else if (r_vld) begin
            r_hold_d = tri_rdata;
        end
    end

    // State, tile count, address counter, held R word and tile-valid pipeline stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            r_hold_q   <= '0;
            tile_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            r_hold_q   <= r_hold_d;
            tile_vld_q <= dm0_en;
        end
    end

    // Tile bus towards the QR core; valid only while the dm0 phase is still live
    assign tile_data      = dm0_rdata;
    assign tile_vld       = tile_vld_q && (state_q == ST_MEM0);
    assign qr_core_unused = {tile_vld, tile_data};

    assign io_mem0_fi = mem0_fi;
    assign io_mem1_fi = mem1_fi;
    assign io_r_vld   = r_vld;
    assign io_r_0     = r_vld ? tri_rdata : r_hold_q;
    assign io_tsqr_fi = tsqr_fi;

endmodule

// File: tb/tb_tsqr_top.sv
// tb/tb_tsqr_top.sv - randomized self-checking bench for tsqr_top
module tb_tsqr_top;
    import tsqr_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_tsqr_en = 1'b0;
    logic [31:0] io_mx_no = 32'd0;
    logic        io_mem0_fi, io_mem1_fi, io_r_vld, io_tsqr_fi;
    word_t       io_r_0;

    int    tests = 0;
    int    fails = 0;
    word_t rw [0:2];
    word_t exp_r = '0;

    always #5 clock = ~clock;

    tsqr_top dut (
        .clock      (clock),
        .reset      (reset),
        .io_tsqr_en (io_tsqr_en),
        .io_mx_no   (io_mx_no),
        .io_mem0_fi (io_mem0_fi),
        .io_mem1_fi (io_mem1_fi),
        .io_r_vld   (io_r_vld),
        .io_r_0     (io_r_0),
        .io_tsqr_fi (io_tsqr_fi)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic preload(input word_t w0, input word_t w1, input word_t w2);
        rw[0] = w0;
        rw[1] = w1;
        rw[2] = w2;
        dut.tri_0.mem_0_ext.Memory[0] = w0;
        dut.tri_0.mem_0_ext.Memory[1] = w1;
        dut.tri_0.mem_0_ext.Memory[2] = w2;
    endtask

    // One run from IDLE. Cycle c=1 is the first cycle after the start edge.
    // abort_at>0 drops enable in that cycle; otherwise enable drops after hold extra DONE cycles.
    task automatic run_case(input logic [31:0] mx, input int hold, input int abort_at, input string tag);
        int n, t0, last;
        logic [3:0] ef;
        n    = (mx > 32'd16) ? 16 : int'(mx);
        t0   = 8 * n;
        last = (abort_at > 0) ? abort_at : t0 + 6 + hold;
        @(posedge clock); #1;
        io_mx_no   = mx;
        io_tsqr_en = 1'b1;
        for (int c = 1; c <= last + 2; c++) begin
            @(posedge clock); #1;
            io_mx_no = $urandom;
            if (c == last) io_tsqr_en = 1'b0;
            @(negedge clock);
            if (c < last) begin
                ef[3] = (c == t0 + 1);
                ef[2] = (c == t0 + 5);
                ef[1] = (c >= t0 + 3) && (c <= t0 + 5);
                ef[0] = (c >= t0 + 6);
                if (ef[1]) exp_r = rw[c - t0 - 3];
            end else if (c == last) begin
                ef = (abort_at > 0) ? 4'b0000 : 4'b0001;
            end else begin
                ef = 4'b0000;
                if (abort_at > 0) exp_r = '0;
            end
            check({tag, "/flags"}, 64'({io_mem0_fi, io_mem1_fi, io_r_vld, io_tsqr_fi}), 64'(ef));
            check({tag, "/r0"}, io_r_0, exp_r);
        end
    endtask

    // Start a run and hit async reset in cycle 'at' of the dm0 phase
    task automatic reset_case(input logic [31:0] mx, input int at, input string tag);
        @(posedge clock); #1;
        io_mx_no   = mx;
        io_tsqr_en = 1'b1;
        repeat (at) @(posedge clock);
        #1;
        reset      = 1'b0;
        io_tsqr_en = 1'b0;
        #1;
        exp_r = '0;
        check({tag, "/flags"}, 64'({io_mem0_fi, io_mem1_fi, io_r_vld, io_tsqr_fi}), 64'(4'b0000));
        check({tag, "/r0"}, io_r_0, exp_r);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset/flags", 64'({io_mem0_fi, io_mem1_fi, io_r_vld, io_tsqr_fi}), 64'(4'b0000));
        check("reset/r0", io_r_0, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        preload(64'h4000000000000000, 64'h3FF0000000000000, 64'hBFE0000000000000);
        run_case(32'd2, 0, 0, "t1_n2");

        preload(rand_word(), rand_word(), rand_word());
        run_case(32'd0, 0, 0, "t2_n0");

        preload(rand_word(), rand_word(), rand_word());
        run_case(32'd100, 0, 0, "t3_clamp");

        preload(rand_word(), rand_word(), rand_word());
        run_case(32'd1, 0, 12, "t4_abort_mem1");
        run_case(32'd1, 0, 0, "t4_rerun");

        preload(rand_word(), rand_word(), rand_word());
        run_case(32'd3, 0, 0, "t5_first");
        reset_case(32'd3, 10, "t5_reset");
        run_case(32'd3, 0, 0, "t5_rerun");

        run_case(32'd2, 10, 0, "t6_hold");

        run_case(32'd4, 0, 20, "abort_mem0");

        for (int i = 0; i < 8; i++) begin
            preload(rand_word(), rand_word(), rand_word());
            run_case(32'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tsqr_top.md
Name: tsqr_top

Overview:
Top-level sequencer of the streaming TSQR (tall-skinny QR) datapath. It holds two preloadable single-port RAMs: dm0 (input matrix tiles) and tri_0 (triangular R buffer). On an enable, it streams every matrix tile out of dm0, then streams the final upper-triangular R factor out of tri_0 on io_r_0. It signals completion of each phase and of the whole factorisation.

Parameters:
BW, 64, data word width (IEEE-754 double bit pattern, treated as opaque bits)
TILE_ROWS, 4, rows per tile
TILE_COLS, 2, columns per tile
MAX_TILES, 16, maximum tile count; dm0 depth = MAX_TILES*TILE_ROWS*TILE_COLS
R_WORDS, TILE_COLS*(TILE_COLS+1)/2 = 3, nonzero R words (r00, r01, r11), row-major upper triangle

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
io_tsqr_en  in  1  level enable; rising into IDLE starts a run
io_mx_no  in  32  tile count, sampled at start
io_mem0_fi  out  1  one-cycle pulse: dm0 stream finished
io_mem1_fi  out  1  one-cycle pulse: R stream finished (coincides with last R word)
io_r_vld  out  1  io_r_0 holds a valid R word
io_r_0  out  BW  R output word
io_tsqr_fi  out  1  run done, held until io_tsqr_en drops

Behaviour:
- Reset (reset=0, async): state IDLE, counters 0, all outputs 0. RAM contents are not cleared.
- RAMs: synchronous read with 1-cycle latency. The array must be reachable as dm0.mem_0_ext.Memory and tri_0.mem_0_ext.Memory so benches can $readmemh preload it. Memory word k of tri_0 holds R word k.
- FSM states: IDLE, MEM0, MEM1, DONE.
- IDLE:
  - When io_tsqr_en=1, latch N = min(io_mx_no, MAX_TILES) and go to MEM0 on the next edge.
- MEM0:
  - Issues dm0 addresses 0..N*8-1 on consecutive cycles.
  - In the cycle after the last address is issued, the last data word is valid internally and io_mem0_fi=1 for exactly one cycle. Go to MEM1.
  - If N=0: no addresses are issued; io_mem0_fi pulses on the first MEM0 cycle.
- MEM1:
  - Issues tri_0 addresses 0..R_WORDS-1 on consecutive cycles.
  - Each word appears one cycle after its address, with io_r_vld=1, for R_WORDS consecutive cycles.
  - io_mem1_fi=1 in the same cycle as the last valid word. Go to DONE.
- DONE: io_tsqr_fi=1, io_r_vld=0, io_r_0 holds the last word. When io_tsqr_en=0, return to IDLE and clear io_tsqr_fi.
- io_tsqr_en dropping in MEM0 or MEM1 aborts the run: go to IDLE next edge and force all outputs to 0. No fi pulse is produced.
- io_r_0 outside a valid cycle: holds its last value (0 after reset).
- io_mx_no changing mid-run has no effect.
- Async reset during a run returns to IDLE immediately.
- dm0 data words are routed to an internal tile bus (tile_data, tile_vld) for the downstream QR core. They are not externally observable.

Decomposition:
- Package tsqr_pkg: BW, TILE_ROWS, TILE_COLS, MAX_TILES, R_WORDS, the state enum, and word_t = logic [BW-1:0].
- Sub-module tsqr_sp_ram (depth/width parameters, inner instance mem_0_ext with array Memory), instantiated twice as dm0 and tri_0.
- The FSM and counters live in tsqr_top.

Test Plan:
1. Preload tri_0 = {0x4000000000000000, 0x3FF0000000000000, 0xBFE0000000000000}; N=2; release reset, then raise en -> io_mem0_fi pulses 17 cycles after the start edge. io_r_vld is high for 3 cycles with those words in order. io_mem1_fi coincides with the third word. io_tsqr_fi stays high.
2. N=0 -> io_mem0_fi on the first MEM0 cycle, then the 3 R words. Total run = 5 cycles.
3. io_mx_no=100 -> clamped to 16; io_mem0_fi arrives after 128 dm0 reads.
4. Drop en during MEM1 after the first R word -> io_r_vld=0 next cycle, no io_mem1_fi, io_tsqr_fi=0. Raising en again restarts from address 0.
5. Assert reset during MEM0 -> all outputs 0 immediately. A rerun produces an identical sequence.
6. In DONE, hold en for 10 cycles -> io_tsqr_fi stays 1. Lower en -> io_tsqr_fi=0 the next cycle.
